// File: rtl/cdc_fifo_wr_ctrl_if.sv
// cdc_fifo_wr_ctrl_if: valid/ready write handshake between a producer and the FIFO write controller.
interface cdc_fifo_wr_ctrl_if #(
    parameter int DATA_BITS = 16
);
    logic                 wr_valid;
    logic                 wr_ready;
    logic [DATA_BITS-1:0] wr_data;

    modport master(output wr_valid, output wr_data, input wr_ready);
    modport slave(input wr_valid, input wr_data, output wr_ready);
endinterface

// File: rtl/cdc_fifo_wr_ctrl.sv
// cdc_fifo_wr_ctrl: write-side pointer, RAM write port and full detection of an async FIFO.
// Define WR_LEVEL_EN to add the registered wr_level / wr_almost_full outputs.
module cdc_fifo_wr_ctrl #(
    parameter int ADDR_BITS   = 4,
    parameter int DATA_BITS   = 16
`ifdef WR_LEVEL_EN
    ,
    parameter int ALMOST_FULL = 14
`endif
) (
    input  logic                 clk,
    input  logic                 reset,
    cdc_fifo_wr_ctrl_if.slave    wr,
    output logic                 mem_we,
    output logic [ADDR_BITS-1:0] mem_waddr,
    output logic [DATA_BITS-1:0] mem_wdata,
    output logic [ADDR_BITS:0]   wptr_gray,
    input  logic [ADDR_BITS:0]   rptr_gray_sync
`ifdef WR_LEVEL_EN
    ,
    output logic [ADDR_BITS:0]   wr_level,
    output logic                 wr_almost_full
`endif
);
    localparam int N = ADDR_BITS;
    // Full when the Gray pointers differ only in their top two bits.
    localparam logic [N:0] FULL_MASK = (N+1)'(3) << (N - 1);

    logic [N:0] wptr_bin_q, wptr_bin_d;
    logic [N:0] wptr_gray_q, wptr_gray_d;
    logic       full;
    logic       accept;

    always_comb begin
        full        = wptr_gray_q == (rptr_gray_sync ^ FULL_MASK);
        wr.wr_ready = ~full & ~reset;
        accept      = wr.wr_valid & wr.wr_ready;
        mem_we      = accept;
        mem_waddr   = wptr_bin_q[N-1:0];
        mem_wdata   = wr.wr_data;
        wptr_bin_d  = wptr_bin_q + (N+1)'(accept);
        wptr_gray_d = wptr_bin_d ^ (wptr_bin_d >> 1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_bin_q  <= '0;
            wptr_gray_q <= '0;
        end else begin
            wptr_bin_q  <= wptr_bin_d;
            wptr_gray_q <= wptr_gray_d;
        end
    end

    assign wptr_gray = wptr_gray_q;

`ifdef WR_LEVEL_EN
    logic [N:0] rptr_bin;
    logic [N:0] wr_level_q, wr_level_d;
    logic       wr_almost_full_q, wr_almost_full_d;

    always_comb begin
        rptr_bin = '0;
        for (int i = 0; i <= N; i++) rptr_bin[i] = ^(rptr_gray_sync >> i);
        wr_level_d       = wptr_bin_q - rptr_bin;
        wr_almost_full_d = 32'(wr_level_d) >= ALMOST_FULL;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_level_q       <= '0;
            wr_almost_full_q <= 1'b0;
        end else begin
            wr_level_q       <= wr_level_d;
            wr_almost_full_q <= wr_almost_full_d;
        end
    end

    assign wr_level       = wr_level_q;
    assign wr_almost_full = wr_almost_full_q;
`endif
endmodule

// File: tb/tb_cdc_fifo_wr_ctrl.sv
// tb_cdc_fifo_wr_ctrl: scoreboard bench; occupancy model built from write/read word counts.
module tb_cdc_fifo_wr_ctrl;
    localparam int AB = 2;
    localparam int DB = 8;
    localparam int D  = 4;
    localparam int AF = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          mem_we;
    logic [AB-1:0] mem_waddr;
    logic [DB-1:0] mem_wdata;
    logic [AB:0]   wptr_gray;
    logic [AB:0]   rptr_gray_sync = '0;
`ifdef WR_LEVEL_EN
    logic [AB:0]   wr_level;
    logic          wr_almost_full;
`endif

    always #5 clk = ~clk;

    cdc_fifo_wr_ctrl_if #(.DATA_BITS(DB)) wr_if();

    cdc_fifo_wr_ctrl #(
        .ADDR_BITS(AB),
        .DATA_BITS(DB)
`ifdef WR_LEVEL_EN
        ,
        .ALMOST_FULL(AF)
`endif
    ) dut (
        .clk(clk),
        .reset(reset),
        .wr(wr_if),
        .mem_we(mem_we),
        .mem_waddr(mem_waddr),
        .mem_wdata(mem_wdata),
        .wptr_gray(wptr_gray),
        .rptr_gray_sync(rptr_gray_sync)
`ifdef WR_LEVEL_EN
        ,
        .wr_level(wr_level),
        .wr_almost_full(wr_almost_full)
`endif
    );

    typedef struct {
        logic          ready;
        logic          we;
        logic [AB-1:0] addr;
        logic [DB-1:0] data;
        logic [AB:0]   gray;
        logic [AB:0]   level;
        logic          afull;
    } exp_t;

    exp_t q[$];
    int tests = 0;
    int fails = 0;
    int wcnt = 0;
    int rcnt = 0;
    int lvl_prev = 0;

    function automatic logic [AB:0] gray(input int v);
        logic [AB:0] b;
        b = AB'(0) + (AB+1)'(v % (2 * D));
        return b ^ (b >> 1);
    endfunction

    task automatic check(input string n, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", n, got, exp);
        end
    endtask

    // One cycle of stimulus; the expected response for that cycle goes to the scoreboard.
    task automatic step(input bit r, input bit v, input logic [DB-1:0] d, input int rc);
        exp_t e;
        int occ;
        @(posedge clk);
        #1;
        reset = r;
        wr_if.wr_valid = v;
        wr_if.wr_data = d;
        rcnt = rc;
        rptr_gray_sync = gray(rcnt);
        occ = wcnt - rcnt;
        e.ready = (occ != D) && !r;
        e.we    = e.ready && v;
        e.addr  = AB'(wcnt % D);
        e.data  = d;
        e.gray  = gray(wcnt);
        e.level = (AB+1)'(lvl_prev);
        e.afull = lvl_prev >= AF;
        q.push_back(e);
        if (r) begin
            wcnt = 0;
            rcnt = 0;
            lvl_prev = 0;
        end else begin
            lvl_prev = occ;
            wcnt += int'(e.we);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                check("wr_ready", 32'(wr_if.wr_ready), 32'(e.ready));
                check("mem_we", 32'(mem_we), 32'(e.we));
                check("wptr_gray", 32'(wptr_gray), 32'(e.gray));
                check("mem_waddr", 32'(mem_waddr), 32'(e.addr));
                if (mem_we) check("mem_wdata", 32'(mem_wdata), 32'(e.data));
`ifdef WR_LEVEL_EN
                check("wr_level", 32'(wr_level), 32'(e.level));
                check("wr_almost_full", 32'(wr_almost_full), 32'(e.afull));
`endif
            end
        end
    end

    initial begin
        wr_if.wr_valid = 1'b0;
        wr_if.wr_data = '0;
        repeat (3) step(1'b1, 1'b1, 8'h55, 0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 8'(8'hA0 + i), 0);
        step(1'b0, 1'b1, 8'hA4, 0);
        step(1'b0, 1'b1, 8'hA4, 1);
        step(1'b0, 1'b0, 8'h00, 1);
        repeat (8) step(1'b0, 1'b1, 8'($urandom), wcnt - 1);
        step(1'b1, 1'b0, 8'h00, 0);
        repeat (3) step(1'b0, 1'b1, 8'($urandom), 0);
        step(1'b1, 1'b1, 8'h00, 0);
        step(1'b0, 1'b1, 8'h3C, 0);
        step(1'b0, 1'b1, 8'h3D, 0);
        step(1'b0, 1'b1, 8'h3E, 0);
        step(1'b0, 1'b0, 8'h00, 0);
        step(1'b0, 1'b0, 8'h00, 1);
        step(1'b0, 1'b0, 8'h00, 1);
        step(1'b0, 1'b0, 8'h00, 1);
        repeat (600) begin
            bit r;
            int rc;
            r = ($urandom % 64) == 0;
            rc = rcnt + ((rcnt < wcnt && ($urandom % 3) == 0) ? 1 : 0);
            step(r, ($urandom % 4) != 0, 8'($urandom), rc);
        end
        @(posedge clk);
        @(negedge clk);
        #1;
        check("scoreboard_drain", 32'(q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
